// File: rtl/seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// seg7_scan_capture
//   Monitors a multiplexed, active-low 7-segment display bus (shared segment
//   lines plus one active-low anode strobe per digit) and rebuilds the BCD
//   digits being shown. A {an,seg} pair is accepted only after it has been
//   seen unchanged for STABLE_CYCLES consecutive samples, which rejects the
//   short glitches around strobe transitions. Digits are collected until
//   every position has been written once, then the whole frame is published
//   in a single cycle.
//
// Parameters
//   DIGITS         number of multiplexed digits (1..8)
//   STABLE_CYCLES  identical consecutive samples needed to accept a pair (>=2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg[6:0]     active-low segments, seg[6]=a .. seg[0]=g
//   an           active-low digit strobes, an[k]=0 selects digit k
//   err_clr      clears the sticky error flag
//   bcd_out      last complete frame, digit k at [4k+3:4k]
//   frame_valid  one-cycle pulse when bcd_out is updated
//   err          sticky error (invalid segment pattern or several strobes)
//
// Optional feature (macro SEG7_DP_EN)
//   Adds input dp (active-low decimal point) and output dp_out (one
//   active-high bit per digit). dp takes part in the stability compare, is
//   captured per digit and published together with bcd_out.
// -----------------------------------------------------------------------------
module seg7_scan_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [DIGITS-1:0]   an,
`ifdef SEG7_DP_EN
    input  logic                dp,
    output logic [DIGITS-1:0]   dp_out,
`endif
    input  logic                err_clr,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                frame_valid,
    output logic                err
);

`ifdef SEG7_DP_EN
    localparam int SW = DIGITS + 8;
    logic [SW-1:0] sample;
    assign sample = {dp, an, seg};
`else
    localparam int SW = DIGITS + 7;
    logic [SW-1:0] sample;
    assign sample = {an, seg};
`endif

    // cnt counts "equal" edges; it never has to exceed STABLE_CYCLES-1.
    localparam int CW = $clog2(STABLE_CYCLES);
    // The first sample of a run is the edge where the pair differs from s_q
    // (cnt cleared); each following equal edge adds one sample. The run
    // reaches STABLE_CYCLES samples on the equal edge that sees this count.
    localparam logic [CW-1:0] COMMIT_CNT = CW'(STABLE_CYCLES - 2);

    typedef enum logic {SETTLE, HELD} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       s_q;
    logic [3:0]          digit_q [DIGITS];
    logic [3:0]          digit_d [DIGITS];
    logic [DIGITS-1:0]   seen_q, seen_d, seen_raw;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [4*DIGITS-1:0] digit_flat;
    logic                fv_q, fv_d;
    logic                err_q, err_d;
    logic                commit;
    logic                write;
    logic                set_err;
    logic                frame;
    logic [DIGITS-1:0]   strobe;
    logic                multi;
    logic [4:0]          dec;

    // Returns {invalid, value}; blank (all segments off) is a legal digit F.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = {1'b0, 4'h0};
            7'b1001111: r = {1'b0, 4'h1};
            7'b0010010: r = {1'b0, 4'h2};
            7'b0000110: r = {1'b0, 4'h3};
            7'b1001100: r = {1'b0, 4'h4};
            7'b0100100: r = {1'b0, 4'h5};
            7'b0100000: r = {1'b0, 4'h6};
            7'b0001111: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0000100: r = {1'b0, 4'h9};
            7'b1111111: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    assign strobe = ~an;
    // Clearing the lowest set bit leaves something only if >1 strobe is low.
    assign multi  = (strobe & (strobe - DIGITS'(1))) != '0;
    assign dec    = decode(seg);

    // Stability FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (sample != s_q) begin
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == COMMIT_CNT) begin
                commit  = 1'b1;
                state_d = HELD;
            end
        end
    end

    // Digit capture on commit
    always_comb begin
        write    = 1'b0;
        set_err  = 1'b0;
        digit_d  = digit_q;
        seen_raw = seen_q;
        if (commit && (strobe != '0)) begin
            if (multi) begin
                set_err = 1'b1;
            end else begin
                write    = 1'b1;
                seen_raw = seen_q | strobe;
                set_err  = dec[4];
                for (int i = 0; i < DIGITS; i++) begin
                    if (strobe[i]) digit_d[i] = dec[3:0];
                end
            end
        end
    end

    // Flatten the next-state digit array so a completing commit publishes
    // the digit it just wrote.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_flat
        assign digit_flat[4*gi +: 4] = digit_d[gi];
    end

    // Frame publish and sticky error
    always_comb begin
        frame  = write && (&seen_raw);
        seen_d = frame ? '0 : seen_raw;
        bcd_d  = frame ? digit_flat : bcd_q;
        fv_d   = frame;
        err_d  = err_q;
        if (err_clr) err_d = 1'b0;
        if (set_err) err_d = 1'b1;   // a new error beats a simultaneous clear
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            s_q     <= '1;
            seen_q  <= '0;
            bcd_q   <= '1;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'hF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= sample;
            seen_q  <= seen_d;
            bcd_q   <= bcd_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            digit_q <= digit_d;
        end
    end

`ifdef SEG7_DP_EN
    logic [DIGITS-1:0] dp_dig_q, dp_dig_d;
    logic [DIGITS-1:0] dp_out_q;

    always_comb begin
        dp_dig_d = dp_dig_q;
        if (write) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (strobe[i]) dp_dig_d[i] = ~dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_dig_q <= '0;
            dp_out_q <= '0;
        end else begin
            dp_dig_q <= dp_dig_d;
            if (frame) dp_out_q <= dp_dig_d;
        end
    end

    assign dp_out = dp_out_q;
`endif

    assign bcd_out     = bcd_q;
    assign frame_valid = fv_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Testbench for seg7_scan_capture (DIGITS=4, STABLE_CYCLES=3).
module tb_seg7_scan_capture;
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        err;
    logic        dp_in = 1'b1;
`ifdef SEG7_DP_EN
    logic        dp;
    logic [3:0]  dp_out;
    assign dp = dp_in;
`endif

    seg7_scan_capture #(.DIGITS(4), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
`ifdef SEG7_DP_EN
        .dp(dp), .dp_out(dp_out),
`endif
        .err_clr(err_clr), .bcd_out(bcd_out),
        .frame_valid(frame_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Segment patterns for digits 0..9 (active low, a..g).
    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100};

    // Reference model: run-length view of the sampled bus.
    logic [11:0] m_prev;
    int          m_run;
    bit          m_have;
    logic [3:0]  m_dig [4];
    logic [3:0]  m_seen, m_dpdig, m_dpout;
    logic [15:0] m_bcd;
    logic        m_fv, m_err;

    int total = 0, bad = 0;
    int mis_edges, obs_pulses, exp_pulses, edge_no, last_fv_edge;

    // One clock edge: drive, advance the model, then observe #1 later.
    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic c);
        logic [11:0] smp;
        logic [3:0]  strb;
        int          k, dv;
        bit          nerr;
        an = a; seg = s; err_clr = c;
        @(posedge clk);
        edge_no++;
        if (rst) begin
            m_run = 0; m_have = 0; m_seen = 0; m_bcd = 16'hFFFF;
            m_fv = 0; m_err = 0; m_dpdig = 0; m_dpout = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
        end else begin
            smp = {dp_in, a, s};
            if (m_have && smp == m_prev) m_run++; else m_run = 1;
            m_prev = smp; m_have = 1; m_fv = 0; nerr = 0;
            if (m_run == SC) begin
                strb = ~a;
                if ($countones(strb) > 1) nerr = 1;
                else if ($countones(strb) == 1) begin
                    k = 0;
                    for (int i = 0; i < 4; i++) if (strb[i]) k = i;
                    dv = (s == 7'h7F) ? 15 : 14;
                    for (int v = 0; v < 10; v++) if (s == pat[v]) dv = v;
                    if (dv == 14) nerr = 1;
                    m_dig[k] = dv[3:0];
                    m_dpdig[k] = ~dp_in;
                    m_seen[k] = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_bcd = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
                        m_dpout = m_dpdig; m_fv = 1; m_seen = 0;
                        exp_pulses++;
                    end
                end
            end
            if (nerr) m_err = 1; else if (c) m_err = 0;
        end
        #1;
        if (frame_valid === 1'b1) begin obs_pulses++; last_fv_edge = edge_no; end
        if (bcd_out !== m_bcd || frame_valid !== m_fv || err !== m_err) mis_edges++;
`ifdef SEG7_DP_EN
        if (dp_out !== m_dpout) mis_edges++;
`endif
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(a, s, 1'b0);
    endtask

    task automatic digit(input int k, input int v);
        hold(~(4'b0001 << k), pat[v], SC);
    endtask

    task automatic clear_counts();
        mis_edges = 0; obs_pulses = 0; exp_pulses = 0; edge_no = 0; last_fv_edge = -1;
    endtask

    task automatic test_reset();
        clear_counts();
        rst = 1'b1;
        step(4'($urandom), 7'($urandom), 1'b0);
        step(4'($urandom), 7'($urandom), 1'b0);
        total++; if (bcd_out !== 16'hFFFF) begin bad++; $display("FAIL reset_bcd: got %h want ffff", bcd_out); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        hold(4'hF, 7'h7F, 3);
        $display("test_reset done");
    endtask

    task automatic test_frame();
        clear_counts();
        hold(4'b1110, 7'b0010010, 3);
        hold(4'b1101, 7'b0000110, 3);
        hold(4'b1011, 7'b1001100, 3);
        hold(4'b0111, 7'b0000100, 3);
        total++; if (obs_pulses !== 1) begin bad++; $display("FAIL frame_pulses: got %0d want 1", obs_pulses); end
        total++; if (last_fv_edge !== 12) begin bad++; $display("FAIL frame_edge: got %0d want 12", last_fv_edge); end
        total++; if (bcd_out !== 16'h9432) begin bad++; $display("FAIL frame_bcd: got %h want 9432", bcd_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL frame_err: got %b want 0", err); end
        total++; if (mis_edges !== 0) begin bad++; $display("FAIL frame_model: got %0d bad edges want 0", mis_edges); end
        $display("test_frame done");
    endtask

    task automatic test_glitch();
        clear_counts();
        hold(4'b1110, 7'b0000000, 2);
        hold(4'hF, 7'h7F, 3);
        total++; if (obs_pulses !== 0) begin bad++; $display("FAIL glitch_pulse: got %0d want 0", obs_pulses); end
        digit(0, 5); digit(1, 6); digit(2, 7); digit(3, 1);
        total++; if (bcd_out !== 16'h1765) begin bad++; $display("FAIL glitch_bcd: got %h want 1765", bcd_out); end
        total++; if (mis_edges !== 0) begin bad++; $display("FAIL glitch_model: got %0d bad edges want 0", mis_edges); end
        $display("test_glitch done");
    endtask

    task automatic test_err();
        clear_counts();
        hold(4'b1101, 7'b1111110, 3);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
        digit(0, 1); digit(2, 2); digit(3, 3);
        total++; if (bcd_out !== 16'h32E1) begin bad++; $display("FAIL err_digitE: got %h want 32e1", bcd_out); end
        step(4'hF, 7'h7F, 1'b1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clr: got %b want 0", err); end
        hold(4'b1110, 7'b0110110, 2);
        step(4'b1110, 7'b0110110, 1'b1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set_wins: got %b want 1", err); end
        step(4'hF, 7'h7F, 1'b1);
        hold(4'hF, 7'h7F, 2);
        total++; if (mis_edges !== 0) begin bad++; $display("FAIL err_model: got %0d bad edges want 0", mis_edges); end
        $display("test_err done");
    endtask

    task automatic test_multi();
        clear_counts();
        digit(0, 7);
        hold(4'b1100, pat[8], 5);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL multi_err: got %b want 1", err); end
        step(4'hF, 7'h7F, 1'b1);
        digit(1, 1); digit(2, 2); digit(3, 3);
        total++; if (obs_pulses !== 1) begin bad++; $display("FAIL multi_pulses: got %0d want 1", obs_pulses); end
        total++; if (bcd_out !== 16'h3217) begin bad++; $display("FAIL multi_bcd: got %h want 3217", bcd_out); end
        total++; if (mis_edges !== 0) begin bad++; $display("FAIL multi_model: got %0d bad edges want 0", mis_edges); end
        $display("test_multi done");
    endtask

    task automatic test_reset_mid();
        clear_counts();
        digit(0, 4); digit(1, 5);
        rst = 1'b1;
        hold(4'hF, 7'h7F, 2);
        rst = 1'b0;
        hold(4'hF, 7'h7F, 2);
        total++; if (bcd_out !== 16'hFFFF) begin bad++; $display("FAIL mid_reset_bcd: got %h want ffff", bcd_out); end
`ifdef SEG7_DP_EN
        dp_in = 1'b0;
`endif
        digit(2, 6);
        dp_in = 1'b1;
        digit(3, 8);
        total++; if (obs_pulses !== 0) begin bad++; $display("FAIL mid_partial: got %0d pulses want 0", obs_pulses); end
        digit(0, 1); digit(1, 2);
        total++; if (obs_pulses !== 1) begin bad++; $display("FAIL mid_pulse: got %0d want 1", obs_pulses); end
        total++; if (bcd_out !== 16'h8621) begin bad++; $display("FAIL mid_bcd: got %h want 8621", bcd_out); end
`ifdef SEG7_DP_EN
        total++; if (dp_out !== 4'b0100) begin bad++; $display("FAIL mid_dp: got %b want 0100", dp_out); end
`endif
        total++; if (mis_edges !== 0) begin bad++; $display("FAIL mid_model: got %0d bad edges want 0", mis_edges); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        int r, n;
        clear_counts();
        for (int p = 0; p < 200; p++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       a = 4'hF;
            else if (r < 10) a = ~(4'b0011 << $urandom_range(0, 2));
            else             a = ~(4'b0001 << $urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 8)       s = 7'($urandom_range(0, 127));
            else if (r < 12) s = 7'h7F;
            else             s = pat[$urandom_range(0, 9)];
`ifdef SEG7_DP_EN
            dp_in = 1'($urandom_range(0, 1));
`endif
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) step(a, s, 1'($urandom_range(0, 9) == 0));
        end
        dp_in = 1'b1;
        total++; if (mis_edges !== 0) begin bad++; $display("FAIL rand_model: got %0d bad edges want 0", mis_edges); end
        total++; if (obs_pulses !== exp_pulses) begin bad++; $display("FAIL rand_pulses: got %0d want %0d", obs_pulses, exp_pulses); end
        total++; if (bcd_out !== m_bcd) begin bad++; $display("FAIL rand_bcd: got %h want %h", bcd_out, m_bcd); end
        total++; if (err !== m_err) begin bad++; $display("FAIL rand_err: got %b want %b", err, m_err); end
        $display("test_random done: %0d frames", exp_pulses);
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0; an = 4'hF; seg = 7'h7F;
        test_reset();
        test_frame();
        test_glitch();
        test_err();
        test_multi();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
